// File: rtl/digit_serial_mul_ctrl_if.sv
// Operand/result handshake bundle for the digit-serial multiplier controller.
interface digit_serial_mul_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p_out;
    logic               mismatch;
    logic               ovf;
    logic [CNT_W-1:0]   err_count;
    logic               clr_count;

    modport master (
        output in_valid, a_in, b_in, out_ready, clr_count,
        input  in_ready, out_valid, p_out, mismatch, ovf, err_count
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready, clr_count,
        output in_ready, out_valid, p_out, mismatch, ovf, err_count
    );
endinterface

// File: rtl/digit_serial_mul_ctrl.sv
// Drives one 2x2 multiplier core digit pair per cycle, accumulates the shifted
// partial products into a 2*WIDTH-bit result and scores it against the exact product.
module digit_serial_mul_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    digit_serial_mul_ctrl_if.slave  bus,
    output logic [1:0]              core_a,
    output logic [1:0]              core_b,
    input  logic [3:0]              core_p
);
    localparam int unsigned N     = WIDTH / 2;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDX_W-1:0] i_r;
    logic [IDX_W-1:0] j_r;
    logic [PW-1:0]    acc;
    logic             ovf_acc;

    logic [PW:0]      sum_c;
    logic [PW-1:0]    exact_c;
    logic [IDX_W-1:0] ni_c;
    logic [IDX_W-1:0] nj_c;
    logic             last_c;

    // Digit index stepping (j inner), shifted accumulate and exact reference.
    always_comb begin
        last_c = (i_r == LAST) && (j_r == LAST);
        ni_c   = i_r;
        nj_c   = j_r + IDX_W'(1);
        if (j_r == LAST) begin
            nj_c = '0;
            ni_c = i_r + IDX_W'(1);
        end
        sum_c   = {1'b0, acc} + ((PW+1)'(core_p) << (2 * (32'(i_r) + 32'(j_r))));
        exact_c = PW'(a_r) * PW'(b_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            a_r           <= '0;
            b_r           <= '0;
            i_r           <= '0;
            j_r           <= '0;
            acc           <= '0;
            ovf_acc       <= 1'b0;
            core_a        <= 2'b00;
            core_b        <= 2'b00;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.p_out     <= '0;
            bus.mismatch  <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.err_count <= '0;
        end else begin
            // Clear beats a same-cycle increment; the counter saturates at all-ones.
            if (bus.clr_count) begin
                bus.err_count <= '0;
            end else if (state == DONE && bus.out_ready && bus.mismatch &&
                         bus.err_count != '1) begin
                bus.err_count <= bus.err_count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r          <= bus.a_in;
                        b_r          <= bus.b_in;
                        i_r          <= '0;
                        j_r          <= '0;
                        acc          <= '0;
                        ovf_acc      <= 1'b0;
                        core_a       <= bus.a_in[1:0];
                        core_b       <= bus.b_in[1:0];
                        bus.in_ready <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum_c[PW-1:0];
                    i_r <= ni_c;
                    j_r <= nj_c;
                    if (sum_c[PW]) begin
                        ovf_acc <= 1'b1;
                    end
                    if (last_c) begin
                        core_a        <= 2'b00;
                        core_b        <= 2'b00;
                        bus.p_out     <= sum_c[PW-1:0];
                        bus.mismatch  <= (sum_c[PW-1:0] != exact_c);
                        bus.ovf       <= ovf_acc | sum_c[PW];
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        core_a <= 2'(a_r >> (2 * 32'(ni_c)));
                        core_b <= 2'(b_r >> (2 * 32'(nj_c)));
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_mul_ctrl.sv
// Bench for digit_serial_mul_ctrl: bench-side 2x2 cores plus a digit-sum reference model.
module tb_digit_serial_mul_ctrl;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned N     = WIDTH / 2;
    localparam int unsigned LAT   = N * N + 1;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] core_a;
    logic [1:0] core_b;
    logic [3:0] core_p;

    int         mode;
    logic [3:0] lut [16];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         exp_err = 0;

    always #5 clk = ~clk;

    digit_serial_mul_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    digit_serial_mul_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .core_a (core_a),
        .core_b (core_b),
        .core_p (core_p)
    );

    // 0 exact, 1 wrong at 3x3, 2 stuck at 15, 3 random lookup table
    function automatic logic [3:0] core_fn(input int m, input logic [1:0] x, input logic [1:0] y);
        logic [3:0] r;
        case (m)
            0:       r = 4'(x) * 4'(y);
            1:       r = (x == 2'd3 && y == 2'd3) ? 4'd0 : 4'(x) * 4'(y);
            2:       r = 4'd15;
            default: r = lut[{x, y}];
        endcase
        return r;
    endfunction

    assign core_p = core_fn(mode, core_a, core_b);

    task automatic ref_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] p, output logic mis, output logic ov);
        longint s = 0;
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++)
                s += longint'(core_fn(mode, 2'(a >> (2 * i)), 2'(b >> (2 * j)))) << (2 * (i + j));
        p   = 16'(s);
        ov  = (s > 64'd65535);
        mis = (p != 16'(32'(a) * 32'(b)));
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, input bit clr);
        logic [15:0] ep;
        logic        em;
        logic        eo;
        int          lat;
        ref_op(a, b, ep, em, eo);
        chk("in_ready_idle", 64'(bus.in_ready), 1);
        bus.a_in = a;
        bus.b_in = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        chk("in_ready_busy", 64'(bus.in_ready), 0);
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(LAT));
        chk("p_out", 64'(bus.p_out), 64'(ep));
        chk("mismatch", 64'(bus.mismatch), 64'(em));
        chk("ovf", 64'(bus.ovf), 64'(eo));
        chk("core_idle", 64'({core_a, core_b}), 0);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.a_in = 8'($urandom);
            bus.b_in = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 64'(bus.out_valid), 1);
            chk("hold_p_out", 64'(bus.p_out), 64'(ep));
            chk("hold_in_ready", 64'(bus.in_ready), 0);
            chk("hold_err_count", 64'(bus.err_count), 64'(exp_err));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.clr_count = clr;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.clr_count = 1'b0;
        if (clr) exp_err = 0;
        else if (em && exp_err < CMAX) exp_err++;
        chk("out_valid_drop", 64'(bus.out_valid), 0);
        chk("in_ready_back", 64'(bus.in_ready), 1);
        chk("err_count", 64'(bus.err_count), 64'(exp_err));
        chk("p_out_kept", 64'(bus.p_out), 64'(ep));
    endtask

    initial begin
        rst = 1'b1;
        mode = 0;
        bus.in_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.out_ready = 1'b0;
        bus.clr_count = 1'b0;
        for (int k = 0; k < 16; k++) lut[k] = 4'(k);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 1);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_p_out", 64'(bus.p_out), 0);
        chk("rst_flags", 64'({bus.mismatch, bus.ovf}), 0);
        chk("rst_err_count", 64'(bus.err_count), 0);
        chk("rst_core", 64'({core_a, core_b}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        mode = 0;
        run_op(8'd200, 8'd150, 0, 1'b0);
        chk("p_200x150", 64'(bus.p_out), 30000);
        run_op(8'd0, 8'd255, 0, 1'b0);
        chk("p_0x255", 64'(bus.p_out), 0);
        run_op(8'd255, 8'd255, 0, 1'b0);
        chk("p_255x255", 64'(bus.p_out), 65025);

        mode = 1;
        run_op(8'd255, 8'd255, 0, 1'b0);
        chk("faulty_p", 64'(bus.p_out), 0);
        chk("faulty_err", 64'(bus.err_count), 1);

        mode = 2;
        run_op(8'd255, 8'd255, 0, 1'b0);
        chk("stub_p", 64'(bus.p_out), 42839);
        chk("stub_ovf", 64'(bus.ovf), 1);

        mode = 1;
        run_op(8'd255, 8'd255, 5, 1'b0);
        run_op(8'd255, 8'd255, 1, 1'b1);
        chk("clr_wins", 64'(bus.err_count), 0);

        // Abort mid-run with an async reset, then a clean operation.
        run_op(8'd255, 8'd255, 0, 1'b0);
        bus.a_in = 8'd255;
        bus.b_in = 8'd255;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_err = 0;
        chk("abort_out_valid", 64'(bus.out_valid), 0);
        chk("abort_err_count", 64'(bus.err_count), 0);
        chk("abort_in_ready", 64'(bus.in_ready), 1);
        chk("abort_core", 64'({core_a, core_b}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mode = 0;
        run_op(8'd3, 8'd3, 0, 1'b0);
        chk("p_3x3", 64'(bus.p_out), 9);

        for (int t = 0; t < 24; t++) begin
            mode = int'($urandom_range(0, 3));
            for (int k = 0; k < 16; k++) lut[k] = 4'($urandom);
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                   ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
